regfile_block_transfer: RTL and testbench

Multi-register block-transfer sequencer for the 16×32 register file. On a start pulse it walks a 16-bit register list and moves each selected register to or from data memory (PUSH/STM or POP/LDM) using register file read port A, the single write port and a req/ack memory handshake. It sits between the decode/control unit and the register file/data memory, and stalls the core via `Busy` while active.

---
 rtl/regfile_block_transfer_if.sv | 38 +++
 rtl/regfile_block_transfer.sv | 255 +++++++++++++++++++++++++
 tb/tb_regfile_block_transfer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_block_transfer_if.sv
// Bus bundle between the block-transfer sequencer and its surroundings:
// control/decode request, register file ports A/C, and the data memory handshake.
// The slave modport is the sequencer itself; the master modport is everything around it.
interface regfile_block_transfer_if;
    logic        Start;
    logic        Load;
    logic [15:0] RegList;
    logic [31:0] BaseAddr;

    logic [3:0]  DirA;
    logic [31:0] ReadDataA;
    logic [3:0]  DirC;
    logic [31:0] WriteData;
    logic        WriteEnable;

    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    logic        Busy;
    logic        Done;
    logic        Fault;

    modport master (
        output Start, Load, RegList, BaseAddr, ReadDataA, MemRData, MemAck,
        input  DirA, DirC, WriteData, WriteEnable, MemReq, MemWrite, MemAddr, MemWData,
               Busy, Done, Fault
    );

    modport slave (
        input  Start, Load, RegList, BaseAddr, ReadDataA, MemRData, MemAck,
        output DirA, DirC, WriteData, WriteEnable, MemReq, MemWrite, MemAddr, MemWData,
               Busy, Done, Fault
    );
endinterface

// File: rtl/regfile_block_transfer.sv
// Multi-register block-transfer sequencer (PUSH/STM and POP/LDM) for the 16x32
// register file. Walks the latched register list in ascending order, one memory
// access per selected register, and stalls the core through Busy while active.
//
// Build option: define REGFILE_SP_WRITEBACK_EN to add the SPWB state, which writes
// the final stack pointer into R13 after a successful non-empty transfer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for Start; latches Load, RegList, BaseAddr
// SETUP  | count registers, compute first address and final SP
// RDREG  | store only: read Ri through port A into the store data register
// MEM    | memory request held until MemAck or timeout
// WBREG  | load only: one-cycle write of the loaded word into Ri
// SPWB   | write final SP into R13 (only with REGFILE_SP_WRITEBACK_EN)
// DONE   | one-cycle Done pulse, Fault qualifies it
module regfile_block_transfer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                     i_clk,
    input logic                     i_rst,
    regfile_block_transfer_if.slave io_bus
);

`ifdef REGFILE_SP_WRITEBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RDREG, S_MEM, S_WBREG, S_SPWB, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RDREG, S_MEM, S_WBREG, S_DONE
    } state_t;
`endif

    // Timeout is a down-counter loaded on MEM entry; expiry is the terminal count 0
    // seen in a cycle without MemAck, which makes MEM last exactly MEM_TIMEOUT cycles.
    localparam logic [31:0] LP_TMO_LOAD = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);
    localparam bit          LP_TMO_EN   = (MEM_TIMEOUT != 0);

    state_t      r_state;
    logic        r_load;
    logic [15:0] r_list;       // registers not yet started
    logic [31:0] r_base;
    logic [3:0]  r_idx;        // register currently being transferred
    logic [31:0] r_tmo_cnt;
`ifdef REGFILE_SP_WRITEBACK_EN
    logic [31:0] r_final_sp;
`endif

    logic [3:0]  r_dir_a;
    logic [3:0]  r_dir_c;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_mem_req;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_fault;

    logic [4:0]  w_count;
    logic [31:0] w_span;
    logic [3:0]  w_next_idx;
    logic [15:0] w_list_rest;

    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int k = 0; k < 16; k++) c = c + {4'd0, v[k]};
        return c;
    endfunction

    function automatic logic [3:0] f_lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int k = 15; k >= 0; k--) if (v[k]) idx = 4'(k);
        return idx;
    endfunction

    // Register count, byte span, and the next register to service from the remaining list
    always_comb begin
        w_count     = f_popcount(r_list);
        w_span      = {25'd0, w_count, 2'b00};
        w_next_idx  = f_lowest(r_list);
        w_list_rest = r_list & ~(16'd1 << w_next_idx);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_load      <= 1'b0;
            r_list      <= '0;
            r_base      <= '0;
            r_idx       <= '0;
            r_tmo_cnt   <= '0;
`ifdef REGFILE_SP_WRITEBACK_EN
            r_final_sp  <= '0;
`endif
            r_dir_a     <= '0;
            r_dir_c     <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    if (io_bus.Start) begin
                        r_load  <= io_bus.Load;
                        r_list  <= io_bus.RegList;
                        r_base  <= io_bus.BaseAddr;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_count == 5'd0) begin
                        r_done  <= 1'b1;
                        r_fault <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        // Both directions fill ascending addresses, so a store starts
                        // below the base and a load starts at it.
                        r_mem_addr <= r_load ? r_base : r_base - w_span;
`ifdef REGFILE_SP_WRITEBACK_EN
                        r_final_sp <= r_load ? r_base + w_span : r_base - w_span;
`endif
                        r_idx  <= w_next_idx;
                        r_list <= w_list_rest;
                        if (r_load) begin
                            r_mem_req   <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_tmo_cnt   <= LP_TMO_LOAD;
                            r_state     <= S_MEM;
                        end else begin
                            r_dir_a <= w_next_idx;
                            r_state <= S_RDREG;
                        end
                    end
                end

                S_RDREG: begin
                    r_mem_wdata <= io_bus.ReadDataA;
                    r_mem_req   <= 1'b1;
                    r_mem_write <= 1'b1;
                    r_tmo_cnt   <= LP_TMO_LOAD;
                    r_state     <= S_MEM;
                end

                S_MEM: begin
                    if (io_bus.MemAck) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        if (r_load) begin
                            r_wdata <= io_bus.MemRData;
                            r_dir_c <= r_idx;
                            r_we    <= 1'b1;
                            r_state <= S_WBREG;
                        end else if (|r_list) begin
                            r_idx   <= w_next_idx;
                            r_list  <= w_list_rest;
                            r_dir_a <= w_next_idx;
                            r_state <= S_RDREG;
                        end else begin
`ifdef REGFILE_SP_WRITEBACK_EN
                            r_dir_c <= 4'd13;
                            r_wdata <= r_final_sp;
                            r_we    <= 1'b1;
                            r_state <= S_SPWB;
`else
                            r_done  <= 1'b1;
                            r_fault <= 1'b0;
                            r_state <= S_DONE;
`endif
                        end
                    end else if (LP_TMO_EN && r_tmo_cnt == 32'd0) begin
                        // Abort without SP writeback; earlier loads stay in the regfile.
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_fault   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 32'd1;
                    end
                end

                S_WBREG: begin
                    if (|r_list) begin
                        r_we        <= 1'b0;
                        r_idx       <= w_next_idx;
                        r_list      <= w_list_rest;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_tmo_cnt   <= LP_TMO_LOAD;
                        r_state     <= S_MEM;
                    end else begin
`ifdef REGFILE_SP_WRITEBACK_EN
                        // Back-to-back write: the SP writeback overrides a loaded R13.
                        r_dir_c <= 4'd13;
                        r_wdata <= r_final_sp;
                        r_we    <= 1'b1;
                        r_state <= S_SPWB;
`else
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_fault <= 1'b0;
                        r_state <= S_DONE;
`endif
                    end
                end

`ifdef REGFILE_SP_WRITEBACK_EN
                S_SPWB: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_fault <= 1'b0;
                    r_state <= S_DONE;
                end
`endif

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.DirA        = r_dir_a;
    assign io_bus.DirC        = r_dir_c;
    assign io_bus.WriteData   = r_wdata;
    assign io_bus.WriteEnable = r_we;
    assign io_bus.MemReq      = r_mem_req;
    assign io_bus.MemWrite    = r_mem_write;
    assign io_bus.MemAddr     = r_mem_addr;
    assign io_bus.MemWData    = r_mem_wdata;
    assign io_bus.Busy        = r_busy;
    assign io_bus.Done        = r_done;
    assign io_bus.Fault       = r_fault;

endmodule

// File: tb/tb_regfile_block_transfer.sv
// Bench for regfile_block_transfer: register file and memory models, a transaction
// model that predicts accesses, writes and Done timing, and one per-cycle compare process.
module tb_regfile_block_transfer;
    localparam int unsigned TMO = 4;
`ifdef REGFILE_SP_WRITEBACK_EN
    localparam int SPW = 1;
`else
    localparam int SPW = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_block_transfer_if bus();

    regfile_block_transfer #(.MEM_TIMEOUT(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    logic [31:0] rf  [16];
    logic [31:0] mem [1024];
    assign bus.ReadDataA = rf[bus.DirA];

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;
    typedef struct packed { logic [3:0] idx; logic [31:0] data; } wr_t;
    acc_t exp_acc[$];
    wr_t  exp_wr[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int exp_done_rel = 0;
    bit exp_fault = 1'b0;
    bit txn_active = 1'b0;
    int wait_cfg = 0;
    bit spur = 1'b0;
    bit mid_start = 1'b0;

    int obs_done_rel;
    bit obs_done_seen;
    bit obs_fault;
    int obs_req_cycles;
    int obs_we_r2;
    int wr_count = 0;

    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict the transaction from the transfer rules using the current rf/mem contents.
    task automatic model_txn(input bit load, input logic [15:0] list, input logic [31:0] base);
        int          n;
        int          rel;
        bit          flt;
        logic [31:0] a;
        exp_acc.delete();
        exp_wr.delete();
        n   = $countones(list);
        a   = load ? base : base - 32'(4 * n);
        rel = 1;
        flt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                if (TMO != 0 && wait_cfg >= int'(TMO)) begin
                    rel += int'(TMO);
                    flt = 1'b1;
                    break;
                end
                if (load) begin
                    exp_acc.push_back('{1'b0, a, mem[a[11:2]]});
                    exp_wr.push_back('{4'(i), mem[a[11:2]]});
                end else begin
                    exp_acc.push_back('{1'b1, a, rf[i]});
                end
                rel += 2 + wait_cfg;
                a += 32'd4;
            end
        end
`ifdef REGFILE_SP_WRITEBACK_EN
        if (n > 0 && !flt) begin
            logic [31:0] sp;
            sp = load ? base + 32'(4 * n) : base - 32'(4 * n);
            exp_wr.push_back('{4'd13, sp});
            rel += 1;
        end
`endif
        rel += 1;
        exp_done_rel = rel;
        exp_fault    = flt;
    endtask

    // Memory responder: ack after wait_cfg request cycles; optional spurious ack when idle.
    initial begin
        int cur_w;
        cur_w = 0;
        bus.MemAck   = 1'b0;
        bus.MemRData = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.MemReq) begin
                if (cur_w >= wait_cfg) begin
                    bus.MemAck   = 1'b1;
                    bus.MemRData = mem[bus.MemAddr[11:2]];
                end else begin
                    bus.MemAck = 1'b0;
                    cur_w++;
                end
            end else begin
                bus.MemAck   = spur;
                bus.MemRData = 32'hBAD0_BAD0;
                cur_w = 0;
            end
        end
    end

    // Per-cycle compare against the model, plus regfile/memory update from DUT strobes
    always @(negedge clk) begin
        int   rel;
        acc_t e;
        wr_t  w;
        if (rst) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            rel = cyc - start_cyc + 1;
            chk("busy", {63'd0, bus.Busy}, {63'd0, txn_active && rel <= exp_done_rel});
            chk("done", {63'd0, bus.Done}, {63'd0, txn_active && rel == exp_done_rel});
            if (bus.Done) begin
                obs_done_seen = 1'b1;
                obs_done_rel  = rel;
                obs_fault     = bus.Fault;
                chk("fault", {63'd0, bus.Fault}, {63'd0, exp_fault});
            end
            if (bus.MemReq) begin
                obs_req_cycles++;
                chk("addr_align", {62'd0, bus.MemAddr[1:0]}, 64'd0);
                if (prev_req && !prev_ack) chk("addr_stable", {32'd0, bus.MemAddr}, {32'd0, prev_addr});
            end
            if (bus.MemReq && bus.MemAck) begin
                if (exp_acc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: got addr %0h expected none", bus.MemAddr);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_addr", {32'd0, bus.MemAddr}, {32'd0, e.addr});
                    chk("acc_we", {63'd0, bus.MemWrite}, {63'd0, e.we});
                    if (e.we) chk("acc_wdata", {32'd0, bus.MemWData}, {32'd0, e.data});
                end
                if (bus.MemWrite) mem[bus.MemAddr[11:2]] = bus.MemWData;
            end
            if (bus.WriteEnable) begin
                wr_count++;
                if (bus.DirC == 4'd2) obs_we_r2++;
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got R%0d=%0h expected none", bus.DirC, bus.WriteData);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_idx", {60'd0, bus.DirC}, {60'd0, w.idx});
                    chk("wr_data", {32'd0, bus.WriteData}, {32'd0, w.data});
                end
                rf[bus.DirC] = bus.WriteData;
            end
            prev_req  = bus.MemReq;
            prev_ack  = bus.MemAck;
            prev_addr = bus.MemAddr;
            if (txn_active && rel >= exp_done_rel) txn_active = 1'b0;
        end
    end

    task automatic do_start(input bit load, input logic [15:0] list, input logic [31:0] base);
        model_txn(load, list, base);
        obs_done_seen  = 1'b0;
        obs_done_rel   = -1;
        obs_fault      = 1'b0;
        obs_req_cycles = 0;
        obs_we_r2      = 0;
        @(posedge clk); #1;
        bus.Start    = 1'b1;
        bus.Load     = load;
        bus.RegList  = list;
        bus.BaseAddr = base;
        @(posedge clk); #1;
        start_cyc  = cyc;
        txn_active = 1'b1;
        bus.Start    = 1'b0;
        bus.Load     = ~load;
        bus.RegList  = 16'hFFFF;
        bus.BaseAddr = 32'hDEAD_0000;
    endtask

    task automatic run_txn(input bit load, input logic [15:0] list, input logic [31:0] base, input int w);
        wait_cfg = w;
        do_start(load, list, base);
        for (int k = 0; k < 400; k++) begin
            if (obs_done_seen) break;
            @(posedge clk); #1;
            bus.Start = mid_start && (k == 1);
        end
        bus.Start = 1'b0;
        chk("done_seen", {63'd0, obs_done_seen}, 64'd1);
        chk("acc_left", 64'(exp_acc.size()), 64'd0);
        chk("wr_left", 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctl"}, {48'd0, bus.Busy, bus.Done, bus.Fault, bus.MemReq, bus.MemWrite,
                             bus.WriteEnable, bus.DirA, bus.DirC, 2'b00}, 64'd0);
        chk({name, "_addr"}, {32'd0, bus.MemAddr}, 64'd0);
        chk({name, "_data"}, {bus.MemWData, bus.WriteData}, 64'd0);
    endtask

    initial begin
        logic [31:0] r13_before;
        logic [31:0] r3_before;
        int          wc0;
        int          we0;

        bus.Start    = 1'b0;
        bus.Load     = 1'b0;
        bus.RegList  = '0;
        bus.BaseAddr = '0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 | 32'(i);
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rf[0]  = 32'hA;
        rf[1]  = 32'hB;
        rf[4]  = 32'hC;
        rf[13] = 32'h100;

        #7;
        chk_outputs_zero("reset");
        @(negedge clk); #1;
        rst = 1'b0;

        // PUSH R0,R1,R4 from SP 0x100
        r13_before = rf[13];
        run_txn(1'b0, 16'h0013, 32'h100, 0);
        chk("push_m0", {32'd0, mem[32'hF4 >> 2]}, 64'hA);
        chk("push_m1", {32'd0, mem[32'hF8 >> 2]}, 64'hB);
        chk("push_m2", {32'd0, mem[32'hFC >> 2]}, 64'hC);
        chk("push_r13", {32'd0, rf[13]}, {32'd0, (SPW != 0) ? 32'hF4 : r13_before});
        chk("push_done_cyc", 64'(obs_done_rel), 64'(8 + SPW));

        // POP R0,R15 from 0xF4
        mem[32'hF4 >> 2] = 32'h11;
        mem[32'hF8 >> 2] = 32'h22;
        r13_before = rf[13];
        run_txn(1'b1, 16'h8001, 32'hF4, 0);
        chk("pop_r0", {32'd0, rf[0]}, 64'h11);
        chk("pop_r15", {32'd0, rf[15]}, 64'h22);
        chk("pop_r13", {32'd0, rf[13]}, {32'd0, (SPW != 0) ? 32'hFC : r13_before});
        chk("pop_fault", {63'd0, obs_fault}, 64'd0);

        // POP R2 with three wait states
        mem[32'h200 >> 2] = 32'h77;
        run_txn(1'b1, 16'h0004, 32'h200, 3);
        chk("wait_req_cycles", 64'(obs_req_cycles), 64'd4);
        chk("wait_we_r2", 64'(obs_we_r2), 64'd1);
        chk("wait_r2", {32'd0, rf[2]}, 64'h77);
        chk("wait_done_cyc", 64'(obs_done_rel), 64'(7 + SPW));

        // Empty list
        we0 = wr_count;
        run_txn(1'b0, 16'h0000, 32'h300, 0);
        chk("empty_req", 64'(obs_req_cycles), 64'd0);
        chk("empty_we", 64'(wr_count - we0), 64'd0);
        chk("empty_done_cyc", 64'(obs_done_rel), 64'd2);

        // PUSH including R13, one wait state, spurious acks outside MEM, Start re-pulsed mid-run
        r13_before = rf[13];
        spur = 1'b1;
        mid_start = 1'b1;
        run_txn(1'b0, 16'h2005, 32'h300, 1);
        spur = 1'b0;
        mid_start = 1'b0;
        chk("push13_mem", {32'd0, mem[32'h2FC >> 2]}, {32'd0, r13_before});
        chk("push13_done_cyc", 64'(obs_done_rel), 64'(11 + SPW));

        // POP into R13: SP writeback wins when enabled
        mem[32'h380 >> 2] = 32'h55;
        run_txn(1'b1, 16'h2000, 32'h380, 0);
        chk("pop13_r13", {32'd0, rf[13]}, {32'd0, (SPW != 0) ? 32'h384 : 32'h55});

        // Timeout: no MemAck ever
        r13_before = rf[13];
        run_txn(1'b1, 16'h0004, 32'h400, 1000);
        chk("tmo_req_cycles", 64'(obs_req_cycles), 64'd4);
        chk("tmo_fault", {63'd0, obs_fault}, 64'd1);
        chk("tmo_r13", {32'd0, rf[13]}, {32'd0, r13_before});
        chk("tmo_done_cyc", 64'(obs_done_rel), 64'd6);

        // Reset in the middle of a POP of R0..R7 after three loads
        for (int i = 0; i < 8; i++) mem[(32'h500 >> 2) + i] = 32'hC0DE_0000 + 32'(i);
        r3_before = rf[3];
        wait_cfg = 0;
        wc0 = wr_count;
        do_start(1'b1, 16'h00FF, 32'h500);
        for (int k = 0; k < 100; k++) begin
            if (wr_count >= wc0 + 3) break;
            @(negedge clk); #1;
        end
        chk("rst_three_loads", 64'(wr_count - wc0), 64'd3);
        txn_active = 1'b0;
        exp_acc.delete();
        exp_wr.delete();
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        chk("rst_no_done", {63'd0, obs_done_seen}, 64'd0);
        chk("rst_r0", {32'd0, rf[0]}, 64'hC0DE_0000);
        chk("rst_r1", {32'd0, rf[1]}, 64'hC0DE_0001);
        chk("rst_r2", {32'd0, rf[2]}, 64'hC0DE_0002);
        chk("rst_r3", {32'd0, rf[3]}, {32'd0, r3_before});

        // Normal PUSH after the reset
        rf[0] = 32'h0000_1234;
        rf[1] = 32'h0000_5678;
        run_txn(1'b0, 16'h0003, 32'h600, 0);
        chk("post_m0", {32'd0, mem[32'h5F8 >> 2]}, 64'h1234);
        chk("post_m1", {32'd0, mem[32'h5FC >> 2]}, 64'h5678);
        chk("post_done_cyc", 64'(obs_done_rel), 64'(6 + SPW));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
